// File: rtl/barycentric_serial.sv
// Serial barycentric-coefficient engine: four signed areas, then one shared restoring divider.
// Define BARYCENTRIC_INSIDE_EN to drive inside_out; otherwise it is tied low.
module barycentric_serial #(
  parameter int COORD_WIDTH = 17,
  parameter int COEFF_WIDTH = 26,
  parameter int FRAC_BITS   = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic [2*COORD_WIDTH-1:0]   point_in,
  input  logic [6*COORD_WIDTH-1:0]   vertices_in,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [3*COEFF_WIDTH-1:0]   coeffs_out,
  output logic [2:0]                 coeffs_negative_out,
  output logic                       degenerate_out,
  output logic                       inside_out
);
  localparam int CW = COORD_WIDTH;
  localparam int CF = COEFF_WIDTH;
  localparam int AW = 2*CW + 2;
  localparam int SH = CF - FRAC_BITS;
  localparam int SW = $clog2(CF);

  typedef enum logic [1:0] {IDLE = 2'd0, AREA = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
  state_t r_state, w_next;

  function automatic logic signed [AW-1:0] area(input logic signed [CW-1:0] px, py, qx, qy, rx, ry);
    logic signed [AW-1:0] dqx, dqy, drx, dry;
    dqx = AW'(qx) - AW'(px);
    dqy = AW'(qy) - AW'(py);
    drx = AW'(rx) - AW'(px);
    dry = AW'(ry) - AW'(py);
    return (dqx * dry) - (drx * dqy);
  endfunction

  function automatic logic [AW-1:0] mag(input logic signed [AW-1:0] v);
    logic [AW-1:0] u;
    u = v;
    return v[AW-1] ? (~u + {{(AW-1){1'b0}}, 1'b1}) : u;
  endfunction

  logic [2*CW-1:0]       r_pt;
  logic [6*CW-1:0]       r_vtx;
  logic signed [AW-1:0]  r_sub [3];
  logic [AW-1:0]         r_div;
  logic                  r_full_neg;
  logic [1:0]            r_sel;
  logic [SW-1:0]         r_step;
  logic [AW-1:0]         r_rem;
  logic [CF-1:0]         r_quo;
  logic                  r_sat;
  logic [3*CF-1:0]       r_coeffs;
  logic [2:0]            r_neg;
  logic                  r_degen;
  logic                  r_valid;

  logic signed [CW-1:0]  w_px, w_py, w_x0, w_y0, w_x1, w_y1, w_x2, w_y2;
  logic signed [AW-1:0]  w_full, w_sa, w_sb, w_sc, w_ld_sub, w_cur;
  logic [AW-1:0]         w_ld_div, w_ld_mag, w_ld_rem, w_rem_nx;
  logic [CF-1:0]         w_ld_quo, w_quo_nx, w_result;
  logic [AW:0]           w_trial;
  logic                  w_ld_sat, w_ge, w_neg, w_last, w_stay_done;

  assign w_px = r_pt[CW-1:0];
  assign w_py = r_pt[2*CW-1:CW];
  assign w_x0 = r_vtx[CW-1:0];
  assign w_y0 = r_vtx[2*CW-1:CW];
  assign w_x1 = r_vtx[3*CW-1:2*CW];
  assign w_y1 = r_vtx[4*CW-1:3*CW];
  assign w_x2 = r_vtx[5*CW-1:4*CW];
  assign w_y2 = r_vtx[6*CW-1:5*CW];

  assign w_full = area(w_x0, w_y0, w_x1, w_y1, w_x2, w_y2);
  assign w_sa   = area(w_px, w_py, w_x1, w_y1, w_x2, w_y2);
  assign w_sb   = area(w_x0, w_y0, w_px, w_py, w_x2, w_y2);
  assign w_sc   = area(w_x0, w_y0, w_x1, w_y1, w_px, w_py);
  assign w_last = (r_step == SW'(CF-1));
  assign w_stay_done = (r_state == DONE) && !(r_valid && ready_in);

  // Divider operand load (next sub-area) and one restoring step.
  always_comb begin
    w_ld_sub = w_sa;
    w_ld_div = r_div;
    w_cur    = r_sub[0];
    if (r_state == AREA) begin
      w_ld_sub = w_sa;
      w_ld_div = mag(w_full);
    end else if (r_sel == 2'd0) begin
      w_ld_sub = r_sub[1];
    end else begin
      w_ld_sub = r_sub[2];
    end
    case (r_sel)
      2'd0:    w_cur = r_sub[0];
      2'd1:    w_cur = r_sub[1];
      default: w_cur = r_sub[2];
    endcase
    // Quotient overflows CF bits exactly when the top part of |sub|<<FRAC_BITS reaches the divisor.
    w_ld_mag = mag(w_ld_sub);
    w_ld_rem = w_ld_mag >> SH;
    w_ld_sat = (w_ld_rem >= w_ld_div);
    w_ld_quo = {w_ld_mag[SH-1:0], {FRAC_BITS{1'b0}}};
    w_trial  = {r_rem, r_quo[CF-1]};
    w_ge     = (w_trial >= {1'b0, r_div});
    if (w_ge) begin
      w_rem_nx = w_trial[AW-1:0] - r_div;
    end else begin
      w_rem_nx = w_trial[AW-1:0];
    end
    w_quo_nx = {r_quo[CF-2:0], w_ge};
    if (r_sat) begin
      w_result = {CF{1'b1}};
    end else begin
      w_result = w_quo_nx;
    end
    w_neg = (w_cur != {AW{1'b0}}) && (w_cur[AW-1] != r_full_neg);
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (valid_in) w_next = AREA; else w_next = IDLE;
      AREA:    if (w_full == {AW{1'b0}}) w_next = DONE; else w_next = DIV;
      DIV:     if (w_last && (r_sel == 2'd2)) w_next = DONE; else w_next = DIV;
      DONE:    if (r_valid && ready_in) w_next = IDLE; else w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, area registration and serial division.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pt       <= {(2*CW){1'b0}};
      r_vtx      <= {(6*CW){1'b0}};
      r_sub[0]   <= {AW{1'b0}};
      r_sub[1]   <= {AW{1'b0}};
      r_sub[2]   <= {AW{1'b0}};
      r_div      <= {AW{1'b0}};
      r_full_neg <= 1'b0;
      r_sel      <= 2'd0;
      r_step     <= {SW{1'b0}};
      r_rem      <= {AW{1'b0}};
      r_quo      <= {CF{1'b0}};
      r_sat      <= 1'b0;
      r_coeffs   <= {(3*CF){1'b0}};
      r_neg      <= 3'b000;
      r_degen    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            r_pt     <= point_in;
            r_vtx    <= vertices_in;
            r_coeffs <= {(3*CF){1'b0}};
            r_neg    <= 3'b000;
            r_degen  <= 1'b0;
          end
        end
        AREA: begin
          r_sub[0]   <= w_sa;
          r_sub[1]   <= w_sb;
          r_sub[2]   <= w_sc;
          r_div      <= w_ld_div;
          r_full_neg <= w_full[AW-1];
          r_degen    <= (w_full == {AW{1'b0}});
          r_sel      <= 2'd0;
          r_step     <= {SW{1'b0}};
          r_rem      <= w_ld_rem;
          r_quo      <= w_ld_quo;
          r_sat      <= w_ld_sat;
        end
        DIV: begin
          if (w_last) begin
            r_coeffs[int'(r_sel)*CF +: CF] <= w_result;
            r_neg[r_sel]                   <= w_neg;
            if (r_sel != 2'd2) begin
              r_sel  <= r_sel + 2'd1;
              r_step <= {SW{1'b0}};
              r_rem  <= w_ld_rem;
              r_quo  <= w_ld_quo;
              r_sat  <= w_ld_sat;
            end
          end else begin
            r_step <= r_step + {{(SW-1){1'b0}}, 1'b1};
            r_rem  <= w_rem_nx;
            r_quo  <= w_quo_nx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result valid is registered one cycle after DONE entry and drops on the handshake edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_valid <= 1'b0;
    else           r_valid <= w_stay_done;
  end

  assign ready_out           = (r_state == IDLE);
  assign valid_out           = r_valid;
  assign coeffs_out          = r_coeffs;
  assign coeffs_negative_out = r_neg;
  assign degenerate_out      = r_degen;

`ifdef BARYCENTRIC_INSIDE_EN
  logic r_inside;

  // Inside flag, qualified by the same timing as valid_out.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_inside <= 1'b0;
    else           r_inside <= w_stay_done && !r_degen && (r_neg == 3'b000);
  end

  assign inside_out = r_inside;
`else
  assign inside_out = 1'b0;
`endif

endmodule
